// File: rtl/chess_move_pkg.sv
// Shared definitions for the move-scan sequencer: move word field layout,
// colours, piece codes, slot order of the square array, and scan states.
// Optional build macro used by the slice: MOVE_SCAN_COLOR_FILTER_EN.
package chess_move_pkg;

   // Move word field layout
   localparam int MV_CAPT_LSB  = 24;   // captured piece
   localparam int MV_CAPT_W    = 6;
   localparam int MV_FINAL_LSB = 16;   // final position
   localparam int MV_FINAL_W   = 6;
   localparam int MV_PIECE_LSB = 8;    // initial piece
   localparam int MV_PIECE_W   = 6;
   localparam int MV_INIT_LSB  = 0;    // initial position
   localparam int MV_INIT_W    = 6;
   localparam int MV_COLOR_BIT = 13;   // colour bit of the initial piece

   localparam logic [31:0] EMPTY_MOVE = 32'h0000_0000;

   localparam logic WHITE = 1'b1;
   localparam logic BLACK = 1'b0;

   // Piece codes
   localparam logic [4:0] PAWN   = 5'b00010;
   localparam logic [4:0] KNIGHT = 5'b00001;
   localparam logic [4:0] BISHOP = 5'b01000;
   localparam logic [4:0] ROOK   = 5'b10000;
   localparam logic [4:0] QUEEN  = 5'b11000;
   localparam logic [4:0] KING   = 5'b00100;

   // Slot order inside a square's move vector
   localparam int SLOT_U   = 0;
   localparam int SLOT_D   = 1;
   localparam int SLOT_L   = 2;
   localparam int SLOT_R   = 3;
   localparam int SLOT_UL  = 4;
   localparam int SLOT_UR  = 5;
   localparam int SLOT_DL  = 6;
   localparam int SLOT_DR  = 7;
   localparam int SLOT_UUL = 8;
   localparam int SLOT_UUR = 9;
   localparam int SLOT_LLU = 10;
   localparam int SLOT_RRU = 11;
   localparam int SLOT_DDL = 12;
   localparam int SLOT_DDR = 13;
   localparam int SLOT_LLD = 14;
   localparam int SLOT_RRD = 15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_FETCH  = 3'd2,
      ST_EMIT   = 3'd3,
      ST_DONE   = 3'd4
   } scan_state_t;

endpackage

// File: rtl/move_scan_ctrl_if.sv
// Square-array and move-stream bundle of the move-scan sequencer.
// Optional build macro affecting the slice: MOVE_SCAN_COLOR_FILTER_EN.
//
// Stream handshake: a move transfers on a rising edge where move_valid and
// move_ready are both high. Once move_valid is raised, move_out stays
// stable and move_valid stays high until that transfer (clear excepted);
// move_ready may change freely and never depends combinationally on
// move_valid at the source.
interface move_scan_ctrl_if #(
   parameter int NUM_SLOTS = 16,
   parameter int MOVE_W    = 32
);
   logic                          sq_enable;
   logic [5:0]                    sq_sel;
   logic [NUM_SLOTS*MOVE_W-1:0]   sq_moves;
   logic [MOVE_W-1:0]             move_out;
   logic                          move_valid;
   logic                          move_ready;

   modport master (
      output sq_enable, sq_sel, move_out, move_valid,
      input  sq_moves, move_ready
   );

   modport slave (
      input  sq_enable, sq_sel, move_out, move_valid,
      output sq_moves, move_ready
   );
endinterface

// File: rtl/move_slot_picker.sv
// Lowest-set-bit priority pick over the pending slots of one square:
// returns the selected move word, its slot index and an any-pending flag.
// Optional build macro of the slice (no effect here): MOVE_SCAN_COLOR_FILTER_EN.
module move_slot_picker #(
   parameter int NUM_SLOTS = 16,
   parameter int MOVE_W    = 32,
   localparam int IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic [NUM_SLOTS*MOVE_W-1:0] words,
   input  logic [NUM_SLOTS-1:0]        mask,
   output logic [MOVE_W-1:0]           word,
   output logic [IDX_W-1:0]            idx,
   output logic                        any
);

   // Walk from the top slot down so the lowest pending slot wins
   always_comb begin
      word = '0;
      idx  = '0;
      any  = |mask;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
         if (mask[k]) begin
            word = words[k*MOVE_W +: MOVE_W];
            idx  = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/move_scan_ctrl.sv
// Move-scan sequencer: enables the square array, waits for propagation,
// walks squares 0..NUM_SQUARES-1 and streams every non-empty move word.
// Build macro MOVE_SCAN_COLOR_FILTER_EN: when defined, only moves whose
// initial-piece colour equals the side to move (latched at start) are sent.
module move_scan_ctrl
   import chess_move_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_SQUARES   = 64,
   parameter int NUM_SLOTS     = 16,
   parameter int MOVE_W        = 32,
   parameter int CNT_W         = 11
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 start,
   input  logic                 engineColor,
   move_scan_ctrl_if.master     scan,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     move_count,
   output scan_state_t          state_dbg
);

   // A zero settle time is treated as one cycle
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int SET_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
   localparam int IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_EFF - 1);
   localparam logic [5:0]       LAST_SQ  = 6'(NUM_SQUARES - 1);

   scan_state_t                 state;
   logic [SET_W-1:0]            set_cnt;
   logic [NUM_SLOTS*MOVE_W-1:0] buf_words;
   logic [NUM_SLOTS-1:0]        pending;
   logic [IDX_W-1:0]            cur_idx;

   logic [NUM_SLOTS-1:0]        live_mask;
   logic [NUM_SLOTS*MOVE_W-1:0] pick_words;
   logic [NUM_SLOTS-1:0]        pick_mask;
   logic [MOVE_W-1:0]           pick_word;
   logic [IDX_W-1:0]            pick_idx;
   logic                        pick_any;
   logic                        handshake;

`ifdef MOVE_SCAN_COLOR_FILTER_EN
   logic color_q;

   // Side to move, frozen for the whole scan
   always_ff @(posedge clk) begin
      if (clear)
         color_q <= BLACK;
      else if (state == ST_IDLE && start)
         color_q <= engineColor;
   end

   // Pending slots of the live square: non-empty and own colour
   always_comb begin
      live_mask = '0;
      for (int k = 0; k < NUM_SLOTS; k++)
         live_mask[k] = (scan.sq_moves[k*MOVE_W +: MOVE_W] != '0) &&
                        (scan.sq_moves[k*MOVE_W + MV_COLOR_BIT] == color_q);
   end
`else
   logic unused_engine_color;
   assign unused_engine_color = engineColor;

   // Pending slots of the live square: every non-empty word
   always_comb begin
      live_mask = '0;
      for (int k = 0; k < NUM_SLOTS; k++)
         live_mask[k] = (scan.sq_moves[k*MOVE_W +: MOVE_W] != '0);
   end
`endif

   assign handshake = scan.move_valid && scan.move_ready;
   assign state_dbg = state;

   // Picker sees the live square in FETCH, and the buffer minus the slot
   // being sent in EMIT, so the next move is ready at the handshake edge
   always_comb begin
      pick_words = buf_words;
      pick_mask  = pending & ~(NUM_SLOTS'(1) << cur_idx);
      if (state == ST_FETCH) begin
         pick_words = scan.sq_moves;
         pick_mask  = live_mask;
      end
   end

   move_slot_picker #(
      .NUM_SLOTS (NUM_SLOTS),
      .MOVE_W    (MOVE_W)
   ) u_picker (
      .words (pick_words),
      .mask  (pick_mask),
      .word  (pick_word),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Scan FSM with registered outputs
   always_ff @(posedge clk) begin
      if (clear) begin
         state           <= ST_IDLE;
         set_cnt         <= '0;
         buf_words       <= '0;
         pending         <= '0;
         cur_idx         <= '0;
         scan.sq_sel     <= '0;
         scan.sq_enable  <= 1'b0;
         scan.move_out   <= '0;
         scan.move_valid <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         move_count      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state          <= ST_SETTLE;
                  set_cnt        <= SET_LOAD;
                  scan.sq_sel    <= '0;
                  scan.sq_enable <= 1'b1;
                  busy           <= 1'b1;
                  move_count     <= '0;
               end
            end
            ST_SETTLE: begin
               if (set_cnt == '0)
                  state <= ST_FETCH;
               else
                  set_cnt <= set_cnt - SET_W'(1);
            end
            ST_FETCH: begin
               buf_words <= scan.sq_moves;
               pending   <= live_mask;
               if (pick_any) begin
                  state           <= ST_EMIT;
                  scan.move_valid <= 1'b1;
                  scan.move_out   <= pick_word;
                  cur_idx         <= pick_idx;
               end else if (scan.sq_sel == LAST_SQ) begin
                  state          <= ST_DONE;
                  scan.sq_enable <= 1'b0;
                  done           <= 1'b1;
               end else begin
                  scan.sq_sel <= scan.sq_sel + 6'd1;
               end
            end
            ST_EMIT: begin
               if (handshake) begin
                  move_count <= move_count + CNT_W'(1);
                  pending    <= pick_mask;
                  if (pick_any) begin
                     scan.move_out <= pick_word;
                     cur_idx       <= pick_idx;
                  end else begin
                     scan.move_valid <= 1'b0;
                     scan.move_out   <= EMPTY_MOVE;
                     if (scan.sq_sel == LAST_SQ) begin
                        state          <= ST_DONE;
                        scan.sq_enable <= 1'b0;
                        done           <= 1'b1;
                     end else begin
                        state       <= ST_FETCH;
                        scan.sq_sel <= scan.sq_sel + 6'd1;
                     end
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_scan_ctrl.sv
// Bench for move_scan_ctrl: a board array feeds the square mux, a reference
// model lists the expected move stream per scan, and a monitor checks each
// transfer, stalls, done timing, counts and clear behaviour.
// Honours MOVE_SCAN_COLOR_FILTER_EN in its reference model.
module tb_move_scan_ctrl;
   import chess_move_pkg::*;

   localparam int SETTLE = 16;
   localparam int NSQ    = 64;
   localparam int NSL    = 16;
   localparam int MW     = 32;
   localparam int CW     = 11;
   localparam int BUDGET = 4000;

   logic          clk = 1'b0;
   logic          clear;
   logic          start;
   logic          engine_color;
   logic          busy;
   logic          done;
   logic [CW-1:0] move_count;
   scan_state_t   state_dbg;

   move_scan_ctrl_if #(.NUM_SLOTS(NSL), .MOVE_W(MW)) scan ();

   move_scan_ctrl #(
      .SETTLE_CYCLES (SETTLE),
      .NUM_SQUARES   (NSQ),
      .NUM_SLOTS     (NSL),
      .MOVE_W        (MW),
      .CNT_W         (CW)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .start       (start),
      .engineColor (engine_color),
      .scan        (scan),
      .busy        (busy),
      .done        (done),
      .move_count  (move_count),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- board model driving the square mux ----------------
   logic [MW-1:0] board [NSQ][NSL];

   always_comb begin
      scan.sq_moves = '0;
      for (int k = 0; k < NSL; k++)
         scan.sq_moves[k*MW +: MW] = board[scan.sq_sel][k];
   end

   // ---------------- scoreboard ----------------
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [MW-1:0] exp_q[$];
   int            exp_sq_q[$];
   int            exp_cycles;
   int            exp_count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: every kept word in square-then-slot order; cycle cost is the
   // settle time, one look per square, one cycle per move, one done cycle.
   task automatic model_build(input logic color);
      logic [MW-1:0] w;
      logic          keep;
      exp_q.delete();
      exp_sq_q.delete();
      exp_cycles = SETTLE;
      for (int sq = 0; sq < NSQ; sq++) begin
         exp_cycles += 1;
         for (int sl = 0; sl < NSL; sl++) begin
            w    = board[sq][sl];
            keep = (w != 0);
`ifdef MOVE_SCAN_COLOR_FILTER_EN
            keep = keep && (w[13] == color);
`endif
            if (keep) begin
               exp_q.push_back(w);
               exp_sq_q.push_back(sq);
               exp_cycles += 1;
            end
         end
      end
      exp_cycles += 1;
      exp_count = exp_q.size();
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_board();
      for (int sq = 0; sq < NSQ; sq++)
         for (int sl = 0; sl < NSL; sl++)
            board[sq][sl] = '0;
   endtask

   task automatic fill_random(input int n);
      int            sq;
      int            sl;
      logic [MW-1:0] w;
      clear_board();
      for (int i = 0; i < n; i++) begin
         sq    = $urandom_range(0, NSQ - 1);
         sl    = $urandom_range(0, NSL - 1);
         w     = $urandom;
         w[13] = 1'($urandom_range(0, 1));
         if (w == 0) w = 32'h1;
         board[sq][sl] = w;
      end
   endtask

   task automatic do_reset();
      clear = 1'b1;
      start = 1'b0;
      engine_color = BLACK;
      scan.move_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   // mode 0: ready always high; 1: random ready plus stray starts and colour
   // changes; 2: ready held low for 'stall' cycles on the first move.
   // Called at a sample point (1 time unit after a rising edge) in IDLE.
   task automatic run_scan(input int mode, input int stall, input logic color);
      int            done_at;
      int            stall_left;
      int            en_bad;
      int            max_sel;
      int            exp_sq;
      logic          prev_hold;
      logic [MW-1:0] prev_word;
      logic [MW-1:0] w;
      model_build(color);
      engine_color    = color;
      start           = 1'b1;
      scan.move_ready = (mode != 2);
      done_at    = -1;
      stall_left = stall;
      en_bad     = 0;
      max_sel    = 0;
      prev_hold  = 1'b0;
      prev_word  = '0;
      for (int s = 0; s < BUDGET && done_at < 0; s++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         // observe
         if (prev_hold) begin
            check("hold_valid", 64'(scan.move_valid), 64'd1);
            check("hold_word", 64'(scan.move_out), 64'(prev_word));
         end
         if (int'(scan.sq_sel) > max_sel) max_sel = int'(scan.sq_sel);
         if (done) begin
            done_at = s;
            if (mode == 0)
               check("done_cycle", 64'(s), 64'(exp_cycles - 1));
            if (mode == 2)
               check("done_cycle_stall", 64'(s),
                     64'(exp_cycles - 1 + ((exp_count > 0) ? stall : 0)));
            check("done_count", 64'(move_count), 64'(exp_count));
            check("done_left", 64'(exp_q.size()), 64'd0);
            check("done_sq_enable", 64'(scan.sq_enable), 64'd0);
            check("done_valid", 64'(scan.move_valid), 64'd0);
         end else begin
            if (!scan.sq_enable || !busy) en_bad++;
            // drive
            case (mode)
               0: scan.move_ready = 1'b1;
               1: begin
                  scan.move_ready = ($urandom_range(0, 2) != 0);
                  start           = ($urandom_range(0, 15) == 0);
                  engine_color    = 1'($urandom_range(0, 1));
               end
               default: begin
                  if (scan.move_valid && stall_left > 0) begin
                     scan.move_ready = 1'b0;
                     stall_left--;
                  end else begin
                     scan.move_ready = 1'b1;
                  end
               end
            endcase
            prev_hold = scan.move_valid && !scan.move_ready;
            prev_word = scan.move_out;
            if (scan.move_valid && scan.move_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_move", 64'(scan.move_out), 64'd0);
               end else begin
                  w      = exp_q.pop_front();
                  exp_sq = exp_sq_q.pop_front();
                  check("move_word", 64'(scan.move_out), 64'(w));
                  check("move_sq", 64'(scan.sq_sel), 64'(exp_sq));
               end
            end
         end
      end
      start = 1'b0;
      if (done_at < 0) begin
         check("scan_timeout", 64'd1, 64'd0);
      end else begin
         check("enable_busy_during_scan", 64'(en_bad), 64'd0);
         check("sq_sel_max", 64'(max_sel), 64'(NSQ - 1));
         @(posedge clk);
         #1;
         check("done_one_cycle", 64'(done), 64'd0);
         check("idle_after_done", 64'(state_dbg), 64'(ST_IDLE));
         check("busy_after_done", 64'(busy), 64'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int wait_cnt;
      clear_board();
      do_reset();

      // reset state
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      check("rst_sq_sel", 64'(scan.sq_sel), 64'd0);
      check("rst_sq_enable", 64'(scan.sq_enable), 64'd0);
      check("rst_move_out", 64'(scan.move_out), 64'd0);
      check("rst_valid", 64'(scan.move_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_count", 64'(move_count), 64'd0);

      // empty board
      run_scan(0, 0, WHITE);

      // two moves on square 20, slot order D then DL
      clear_board();
      board[20][SLOT_D]  = 32'h000C_1814;
      board[20][SLOT_DL] = 32'h0015_1814;
      run_scan(0, 0, BLACK);

      // same moves, first transfer stalled for 5 cycles
      run_scan(2, 5, BLACK);

      // first and last squares
      clear_board();
      board[0][SLOT_U]     = 32'h0001_0200;
      board[0][SLOT_RRD]   = 32'h1E0B_0200;
      board[63][SLOT_L]    = 32'h003E_103F;
      run_scan(0, 0, BLACK);

      // one own-colour and one opponent word for BLACK
      clear_board();
      board[10][SLOT_U] = 32'h0000_2A0A;
      board[10][SLOT_R] = 32'h0000_0A0A;
      run_scan(0, 0, BLACK);
      run_scan(0, 0, WHITE);

      // clear while a move is waiting in EMIT
      clear_board();
      board[5][SLOT_UR] = 32'h0102_0305;
      board[6][SLOT_DR] = 32'h0203_0406;
      engine_color      = BLACK;
      start             = 1'b1;
      scan.move_ready   = 1'b0;
      @(posedge clk);
      #1;
      start    = 1'b0;
      wait_cnt = 0;
      while (!scan.move_valid && wait_cnt < 200) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      check("clr_reached_emit", 64'(scan.move_valid), 64'd1);
      repeat (2) @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr_state", 64'(state_dbg), 64'(ST_IDLE));
      check("clr_valid", 64'(scan.move_valid), 64'd0);
      check("clr_move_out", 64'(scan.move_out), 64'd0);
      check("clr_sq_sel", 64'(scan.sq_sel), 64'd0);
      check("clr_sq_enable", 64'(scan.sq_enable), 64'd0);
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_done", 64'(done), 64'd0);
      check("clr_count", 64'(move_count), 64'd0);
      @(posedge clk);
      #1;
      check("clr_no_done", 64'(done), 64'd0);
      scan.move_ready = 1'b1;
      run_scan(0, 0, BLACK);

      // randomized boards with random backpressure
      for (int i = 0; i < 6; i++) begin
         fill_random($urandom_range(1, 40));
         run_scan(1, 0, 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 2; i++) begin
         fill_random($urandom_range(1, 30));
         run_scan(0, 0, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
